// File: rtl/mem_load_wb_stage_pkg.sv
// Shared definitions for the mem1 -> write-back load stage: widths, width codes,
// and the load sideband record carried from mem0 to mem1 completion.
package mem_load_wb_stage_pkg;

    localparam int EXP_W = 7;
    localparam int RD_W  = 5;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] addr_lo;
        logic [1:0] width;
        logic       sign;
        logic       write;
    } sideband_t;

endpackage

// File: rtl/mem_load_wb_stage_chk.sv
// Protocol checker: a mem1 completion must always have a matching mem0 sideband entry.
module mem_load_wb_stage_chk (
    input logic clk,
    input logic rstn,
    input logic advance,
    input logic m1_en,
    input logic sb_valid
);

    a_m1_has_sideband: assert property (
        @(posedge clk) disable iff (!rstn) (advance && m1_en) |-> sb_valid
    ) else $error("mem1 completion without a valid mem0 sideband entry");

endmodule

// File: rtl/mem_load_wb_stage_load_align_ext.sv
// Combinational load aligner: selects the addressed byte/half of the raw word
// and zero- or sign-extends it to 32 bits. Word loads pass through unchanged.
module load_align_ext
    import mem_load_wb_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Field select and extension
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = data;
        case (addr_lo)
            2'd0:    byte_s = data[7:0];
            2'd1:    byte_s = data[15:8];
            2'd2:    byte_s = data[23:16];
            2'd3:    byte_s = data[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = data[31:16];
        end else begin
            half_s = data[15:0];
        end
        case (width)
            W_BYTE:  result = {{24{sign & byte_s[7]}}, byte_s};
            W_HALF:  result = {{16{sign & half_s[15]}}, half_s};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_load_wb_stage.sv
// Stage between mem1 and write-back: holds load sideband from mem0, registers
// the mem1 result with aligned/extended load data and drives the write-back bus.
module mem_load_wb_stage
    import mem_load_wb_stage_pkg::*;
#(
    parameter int EXP_W = mem_load_wb_stage_pkg::EXP_W,
    parameter int RD_W  = mem_load_wb_stage_pkg::RD_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_ext,
    input  logic             stall_by_cache,
    input  logic             flush,
    input  logic             m0_en,
    input  logic [1:0]       m0_addr_lo,
    input  logic [1:0]       m0_width,
    input  logic             m0_sign,
    input  logic             m0_write,
    input  logic             m1_en,
    input  logic [RD_W-1:0]  m1_rd,
    input  logic [31:0]      m1_data,
    input  logic [EXP_W-1:0] m1_exp,
    input  logic [31:0]      m1_badv,
    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [31:0]      wb_data,
    output logic [EXP_W-1:0] wb_exp,
    output logic [31:0]      wb_badv
);

    sideband_t         sb_r;
    logic              advance_s;
    logic              store_s;
    logic              has_exp_s;
    logic [1:0]        eff_addr_s;
    logic [1:0]        eff_width_s;
    logic              eff_sign_s;
    logic [31:0]       aligned_s;
    logic [31:0]       data_next_s;
    logic [RD_W-1:0]   rd_next_s;

    // Stage control and effective load attributes; a missing sideband entry degrades to a word load
    always_comb begin
        advance_s   = !stall_ext && !stall_by_cache;
        has_exp_s   = |m1_exp;
        store_s     = 1'b0;
        eff_addr_s  = 2'd0;
        eff_width_s = W_WORD;
        eff_sign_s  = 1'b0;
        if (sb_r.valid) begin
            store_s     = sb_r.write;
            eff_addr_s  = sb_r.addr_lo;
            eff_width_s = sb_r.width;
            eff_sign_s  = sb_r.sign;
        end else begin
            store_s     = 1'b0;
            eff_addr_s  = 2'd0;
            eff_width_s = W_WORD;
            eff_sign_s  = 1'b0;
        end
    end

    load_align_ext u_align (
        .data    (m1_data),
        .addr_lo (eff_addr_s),
        .width   (eff_width_s),
        .sign    (eff_sign_s),
        .result  (aligned_s)
    );

    // Result shaping: stores, faulting ops and bubbles never write a register
    always_comb begin
        rd_next_s   = {RD_W{1'b0}};
        data_next_s = 32'h0000_0000;
        if (m1_en && !store_s && !has_exp_s) begin
            rd_next_s   = m1_rd;
            data_next_s = aligned_s;
        end else begin
            rd_next_s   = {RD_W{1'b0}};
            data_next_s = 32'h0000_0000;
        end
    end

    // Sideband register: captured at mem0 issue, consumed at mem1 completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_r <= '{valid: 1'b0, addr_lo: 2'd0, width: 2'd0, sign: 1'b0, write: 1'b0};
        end else if (flush) begin
            sb_r.valid <= 1'b0;
        end else if (advance_s) begin
            sb_r <= '{valid: m0_en, addr_lo: m0_addr_lo, width: m0_width,
                      sign: m0_sign, write: m0_write};
        end
    end

    // Output register; flush kills validity but keeps exceptions already captured for commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid <= 1'b0;
            wb_rd    <= {RD_W{1'b0}};
            wb_data  <= 32'h0000_0000;
            wb_exp   <= {EXP_W{1'b0}};
            wb_badv  <= 32'h0000_0000;
        end else begin
            if (flush) begin
                wb_valid <= 1'b0;
            end else if (advance_s) begin
                wb_valid <= m1_en;
            end
            if (advance_s) begin
                wb_rd   <= rd_next_s;
                wb_data <= data_next_s;
                if (!flush) begin
                    wb_exp  <= m1_exp;
                    wb_badv <= m1_badv;
                end
            end
        end
    end

    mem_load_wb_stage_chk u_chk (
        .clk      (clk),
        .rstn     (rstn),
        .advance  (advance_s),
        .m1_en    (m1_en),
        .sb_valid (sb_r.valid)
    );

endmodule
